lifting_update_ctrl: RTL and testbench
======================================

Name: lifting_update_ctrl

Overview:
- Frame sequencer for the DWT lifting predict/update datapath.
- Pops even/odd sample pairs from the split input FIFOs and enables the predict stage.
- Tracks each issued pair through the update stage's fixed register latency, then drives even_rd_en, internal_valid and valid_coarseOut so the update stage emits exactly one coarse coefficient per pair.
- Signals frame completion to the top-level transform controller.

Parameters:
- N_PAIRS, 8, even/odd pairs per frame (≥1); frame yields N_PAIRS coarse coefficients.
- PIPE_LAT, 2, cycles from pair issue to coarse_coefficient valid at the update stage output (≥1).
- CNT_W, $clog2(N_PAIRS+1), width of the pair/output counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  begin one frame; sampled in IDLE only.
- even_empty  input  1  even-sample FIFO empty.
- odd_empty  input  1  odd-sample FIFO empty.
- out_space  input  1  downstream coarse buffer has ≥PIPE_LAT+1 free slots.
- even_rd_en  output  1  pop even FIFO; also drives update-stage even_rd_en.
- odd_rd_en  output  1  pop odd FIFO.
- predict_en  output  1  predict stage consumes the current pair.
- internal_valid  output  1  a following detail coefficient exists for the current coarse output.
- valid_coarseOut  output  1  coarse_coefficient valid this cycle.
- busy  output  1  frame in progress (state ≠ IDLE).
- done  output  1  one-cycle pulse at frame end.
- out_cnt  output  CNT_W  coarse outputs emitted in the current frame.

Behaviour:
- Reset (rst=0, async): state=IDLE; issue counter, out_cnt and the valid shift register cleared; every output 0. Effect is immediate, including mid-frame. In-flight datapath results are discarded (valid never asserted for them).
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: start=1 at a clock edge → RUN; both counters cleared on that edge. start in any other state is ignored.
- RUN, issue condition: issue = !even_empty && !odd_empty && out_space.
  - On issue: even_rd_en = odd_rd_en = predict_en = 1 in the same cycle (combinational from state and inputs); issue counter increments.
  - No partial issue: one FIFO empty → neither is popped.
  - Issue on the N_PAIRS-th pair → FLUSH next cycle.
- Valid tracking: PIPE_LAT-deep shift register, advancing every cycle (datapath registers have no stall), shifts in {issue, last_pair}.
  - valid_coarseOut = tail valid bit, so it is high exactly PIPE_LAT cycles after each issue.
  - internal_valid = valid_coarseOut && !tail last_pair bit. It is low only on the final coarse output of the frame (boundary: no next detail).
  - out_cnt increments on each valid_coarseOut, saturates at N_PAIRS.
- out_space gates issue only; outputs already in flight are always emitted.
- FLUSH: no issue. When the shift register holds no valid bit (out_cnt == N_PAIRS) → DONE.
- DONE: done=1 and busy=1 for one cycle → IDLE. A start held high is accepted on the following IDLE cycle, giving a minimum frame-to-frame gap of 2 cycles.
- busy = 1 in RUN, FLUSH and DONE.
- Counters never wrap within a frame; issue is blocked once the issue counter equals N_PAIRS.
- Assertions (bench):
  - even_rd_en == odd_rd_en.
  - No rd_en while either FIFO is empty.
  - out_cnt ≤ N_PAIRS.
  - done only in DONE.

Test Plan (N_PAIRS=4, PIPE_LAT=2, cycle 0 = edge sampling start):
- Basic frame, FIFOs always non-empty, out_space=1 → rd_en/predict_en high cycles 1–4; valid_coarseOut high cycles 3–6; internal_valid high 3–5, low 6; done cycle 7; busy 1–7; out_cnt=4.
- even_empty high cycles 2–3 → issues at 1,4,5,6; odd_rd_en never high alone; valid_coarseOut at 3,6,7,8; done cycle 9.
- out_space low cycles 2–5 → issues at 1,6,7,8; in-flight output from cycle 1 still appears at cycle 3; done cycle 11.
- rst low asynchronously mid-cycle 3 → all outputs 0 immediately, no valid_coarseOut at cycles 3–6. After release, start → full 4-output frame with the correct internal_valid pattern.
- start pulsed at cycles 2 and 5 during a frame → ignored, exactly one done.
- Rebuild with N_PAIRS=1: single valid_coarseOut with internal_valid=0; start held high continuously → frames repeat with done every 5 cycles.

Source files
------------

// File: rtl/lifting_update_ctrl_if.sv
// Handshake bundle between the lifting frame sequencer and its surroundings.
//   slave  : sequencer side (consumes FIFO/buffer status, drives strobes/status)
//   master : environment side (FIFOs, downstream buffer, transform controller)
// Signals:
//   start           begin one frame
//   even_empty      even-sample FIFO empty
//   odd_empty       odd-sample FIFO empty
//   out_space       downstream coarse buffer has room for everything in flight
//   even_rd_en      pop even FIFO / update-stage even_rd_en
//   odd_rd_en       pop odd FIFO
//   predict_en      predict stage consumes current pair
//   internal_valid  a following detail coefficient exists for this coarse output
//   valid_coarseOut coarse coefficient valid this cycle
//   busy            frame in progress
//   done            one-cycle frame-end pulse
//   out_cnt         coarse outputs emitted in the current frame
interface lifting_update_ctrl_if #(
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic             even_empty;
  logic             odd_empty;
  logic             out_space;
  logic             even_rd_en;
  logic             odd_rd_en;
  logic             predict_en;
  logic             internal_valid;
  logic             valid_coarseOut;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] out_cnt;

  modport master (
    output start, even_empty, odd_empty, out_space,
    input  even_rd_en, odd_rd_en, predict_en, internal_valid, valid_coarseOut,
    input  busy, done, out_cnt
  );

  modport slave (
    input  start, even_empty, odd_empty, out_space,
    output even_rd_en, odd_rd_en, predict_en, internal_valid, valid_coarseOut,
    output busy, done, out_cnt
  );
endinterface

// File: rtl/lifting_update_ctrl.sv
// Frame sequencer for the DWT lifting predict/update datapath.
// Pops even/odd sample pairs, enables the predict stage, tracks each issued pair
// through the update stage's fixed latency and flags every coarse output, then
// pulses done when the last coarse coefficient of the frame has been emitted.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  handshake bundle (slave side), see lifting_update_ctrl_if
module lifting_update_ctrl #(
  parameter int unsigned N_PAIRS  = 8,
  parameter int unsigned PIPE_LAT = 2,
  parameter int unsigned CNT_W    = $clog2(N_PAIRS + 1)
) (
  input logic                  clk,
  input logic                  rst,
  lifting_update_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] PairsMax  = CNT_W'(N_PAIRS);
  localparam logic [CNT_W-1:0] PairsLast = CNT_W'(N_PAIRS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
  // Valid / last-pair tracking; new entries enter at the top, index 0 is the tail.
  logic [PIPE_LAT-1:0] vld_q, vld_d;
  logic [PIPE_LAT-1:0] last_q, last_d;

  logic issue;
  logic last_pair;
  logic frame_start;

  assign frame_start = (state_q == StIdle) && bus.start;
  assign issue       = (state_q == StRun) && (issue_cnt_q != PairsMax) &&
                       !bus.even_empty && !bus.odd_empty && bus.out_space;
  assign last_pair   = issue && (issue_cnt_q == PairsLast);

  // The update-stage registers never stall, so the tracker shifts every cycle.
  if (PIPE_LAT == 1) begin : g_lat1
    assign vld_d  = issue;
    assign last_d = last_pair;
  end else begin : g_latn
    assign vld_d  = {issue, vld_q[PIPE_LAT-1:1]};
    assign last_d = {last_pair, last_q[PIPE_LAT-1:1]};
  end

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    state_d     = state_q;

    if (frame_start) begin
      issue_cnt_d = '0;
      out_cnt_d   = '0;
    end else begin
      if (issue) begin
        issue_cnt_d = issue_cnt_q + CNT_W'(1);
      end
      if (vld_q[0] && (out_cnt_q != PairsMax)) begin
        out_cnt_d = out_cnt_q + CNT_W'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (last_pair) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        // Leave as the final coarse output is counted so done follows it directly.
        if (out_cnt_d == PairsMax) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      vld_q       <= '0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      vld_q       <= vld_d;
      last_q      <= last_d;
    end
  end

  assign bus.even_rd_en      = issue;
  assign bus.odd_rd_en       = issue;
  assign bus.predict_en      = issue;
  assign bus.valid_coarseOut = vld_q[0];
  assign bus.internal_valid  = vld_q[0] && !last_q[0];
  assign bus.busy            = (state_q != StIdle);
  assign bus.done            = (state_q == StDone);
  assign bus.out_cnt         = out_cnt_q;

endmodule

// File: tb/tb_lifting_update_ctrl.sv
module tb_lifting_update_ctrl;

  localparam int NP = 4;
  localparam int PL = 2;

  logic clk;
  logic rst;

  lifting_update_ctrl_if #(.CNT_W(3)) bus4 ();
  lifting_update_ctrl_if #(.CNT_W(1)) bus1 ();

  lifting_update_ctrl #(.N_PAIRS(NP), .PIPE_LAT(PL), .CNT_W(3)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  lifting_update_ctrl #(.N_PAIRS(1), .PIPE_LAT(PL), .CNT_W(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural model: frames as issue/emit timestamps. Interval after edge
  // 'cyc' is labelled cyc+1 (the edge at which its values are sampled).
  int cyc = 0;
  bit m_active;
  int m_issued;
  int m_emitted;
  int m_done_at;
  int due[$];
  bit e_issue, e_valid, e_iv, e_done;

  task automatic calc_exp();
    e_issue = m_active && (m_issued < NP) && !bus4.even_empty && !bus4.odd_empty &&
              bus4.out_space;
    e_valid = (due.size() > 0) && (due[0] == cyc + 1);
    e_iv    = e_valid && (m_emitted != NP - 1);
    e_done  = (m_done_at == cyc + 1);
  endtask

  initial begin
    int lbl;
    m_active = 0; m_issued = 0; m_emitted = 0; m_done_at = -1;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_active = 0; m_issued = 0; m_emitted = 0; m_done_at = -1;
        due.delete();
      end else begin
        calc_exp();
        lbl = cyc + 1;
        if (!m_active) begin
          if (bus4.start) begin
            m_active = 1; m_issued = 0; m_emitted = 0; m_done_at = -1;
            due.delete();
          end
        end else begin
          if (e_issue) begin
            due.push_back(lbl + PL);
            m_issued++;
          end
          if (e_valid) begin
            void'(due.pop_front());
            m_emitted++;
            if (m_emitted == NP) m_done_at = lbl + 1;
          end
          if (e_done) m_active = 0;
        end
        cyc = lbl;
      end
    end
  end

  // Compare process: mid-cycle, against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        calc_exp();
        chk("even_rd_en", int'(bus4.even_rd_en), int'(e_issue));
        chk("odd_rd_en", int'(bus4.odd_rd_en), int'(e_issue));
        chk("predict_en", int'(bus4.predict_en), int'(e_issue));
        chk("valid_coarseOut", int'(bus4.valid_coarseOut), int'(e_valid));
        chk("internal_valid", int'(bus4.internal_valid), int'(e_iv));
        chk("done", int'(bus4.done), int'(e_done));
        chk("busy", int'(bus4.busy), int'(m_active));
        chk("out_cnt", int'(bus4.out_cnt), m_emitted);
        chk("rd_while_empty",
            int'(bus4.odd_rd_en && (bus4.even_empty || bus4.odd_empty)), 0);
      end
    end
  end

  logic [15:0] rd_m, vl_m, iv_m, dn_m, bz_m;

  // Drives label t's inputs for t = 0..n-1 (label 0 = edge that samples start)
  // and records outputs per label. Entered and left just after a rising edge.
  task automatic run_frame(input logic [15:0] ee, input logic [15:0] oe,
                           input logic [15:0] sp, input logic [15:0] st, input int n);
    rd_m = '0; vl_m = '0; iv_m = '0; dn_m = '0; bz_m = '0;
    for (int t = 0; t < n; t++) begin
      bus4.even_empty = ee[t];
      bus4.odd_empty  = oe[t];
      bus4.out_space  = sp[t];
      bus4.start      = st[t];
      @(negedge clk);
      rd_m[t] = bus4.even_rd_en;
      vl_m[t] = bus4.valid_coarseOut;
      iv_m[t] = bus4.internal_valid;
      dn_m[t] = bus4.done;
      bz_m[t] = bus4.busy;
      @(posedge clk);
      #1;
    end
    bus4.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  logic [15:0] v1_m, d1_m, i1_m, b1_m;

  initial begin
    rst = 1'b0;
    bus4.start = 0; bus4.even_empty = 0; bus4.odd_empty = 0; bus4.out_space = 1;
    bus1.start = 0; bus1.even_empty = 0; bus1.odd_empty = 0; bus1.out_space = 1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_busy", int'(bus4.busy), 0);
    chk("reset_out_cnt", int'(bus4.out_cnt), 0);
    chk("reset_valid", int'(bus4.valid_coarseOut), 0);

    // Basic frame.
    run_frame(16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 16);
    chk("basic_rd", int'(rd_m), 16'h001E);
    chk("basic_valid", int'(vl_m), 16'h0078);
    chk("basic_iv", int'(iv_m), 16'h0038);
    chk("basic_done", int'(dn_m), 16'h0080);
    chk("basic_busy", int'(bz_m), 16'h00FE);
    chk("basic_out_cnt", int'(bus4.out_cnt), 4);

    // even FIFO empty at labels 2-3.
    run_frame(16'h000C, 16'h0000, 16'hFFFF, 16'h0001, 16);
    chk("even_empty_rd", int'(rd_m), 16'h0072);
    chk("even_empty_valid", int'(vl_m), 16'h01C8);
    chk("even_empty_iv", int'(iv_m), 16'h00C8);
    chk("even_empty_done", int'(dn_m), 16'h0200);

    // out_space low at labels 2-5.
    run_frame(16'h0000, 16'h0000, 16'hFFC3, 16'h0001, 16);
    chk("space_rd", int'(rd_m), 16'h01C2);
    chk("space_valid", int'(vl_m), 16'h0708);
    chk("space_iv", int'(iv_m), 16'h0308);
    chk("space_done", int'(dn_m), 16'h0800);

    // Stray start pulses during a frame.
    run_frame(16'h0000, 16'h0000, 16'hFFFF, 16'h0025, 16);
    chk("restart_done", int'(dn_m), 16'h0080);
    chk("restart_valid", int'(vl_m), 16'h0078);

    // Asynchronous reset mid-cycle 3.
    run_frame(16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 3);
    chk("prereset_rd", int'(rd_m), 16'h0006);
    #1;
    chk("prereset_valid", int'(bus4.valid_coarseOut), 1);
    rst = 1'b0;
    #1;
    chk("rst_rd", int'(bus4.even_rd_en), 0);
    chk("rst_predict", int'(bus4.predict_en), 0);
    chk("rst_valid", int'(bus4.valid_coarseOut), 0);
    chk("rst_iv", int'(bus4.internal_valid), 0);
    chk("rst_busy", int'(bus4.busy), 0);
    chk("rst_done", int'(bus4.done), 0);
    chk("rst_out_cnt", int'(bus4.out_cnt), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    run_frame(16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 6);
    chk("postrst_valid", int'(vl_m), 0);
    chk("postrst_busy", int'(bz_m), 0);
    run_frame(16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 16);
    chk("postrst_frame_valid", int'(vl_m), 16'h0078);
    chk("postrst_frame_iv", int'(iv_m), 16'h0038);
    chk("postrst_frame_done", int'(dn_m), 16'h0080);

    // Single-pair build with start held high.
    v1_m = '0; d1_m = '0; i1_m = '0; b1_m = '0;
    bus1.start = 1'b1;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      v1_m[t] = bus1.valid_coarseOut;
      d1_m[t] = bus1.done;
      i1_m[t] = bus1.internal_valid;
      b1_m[t] = bus1.busy;
      @(posedge clk);
      #1;
    end
    bus1.start = 1'b0;
    chk("n1_valid", int'(v1_m), 16'h2108);
    chk("n1_done", int'(d1_m), 16'h4210);
    chk("n1_iv", int'(i1_m), 0);
    chk("n1_busy", int'(b1_m), 16'h7BDE);

    repeat (8) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
